branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_if.sv | 32 +++
 rtl/branch_resolve.sv | 126 ++++++++++++
 tb/tb_branch_resolve.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Request/result bundle for the branch resolution unit.
// The slave side is the resolver; the master side issues branches and consumes results.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_dataA;
  logic [XLEN-1:0] i_dataB;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_imm;
  logic            i_pred_taken;
  logic            o_valid;
  logic            i_ready;
  logic            o_taken;
  logic            o_brEq;
  logic            o_brLT;
  logic            o_mispredict;
  logic            o_illegal;
  logic [XLEN-1:0] o_target;

  modport master (
    output i_valid, i_funct3, i_dataA, i_dataB, i_pc, i_imm, i_pred_taken, i_ready,
    input  o_ready, o_valid, o_taken, o_brEq, o_brLT, o_mispredict, o_illegal, o_target
  );

  modport slave (
    input  i_valid, i_funct3, i_dataA, i_dataB, i_pc, i_imm, i_pred_taken, i_ready,
    output o_ready, o_valid, o_taken, o_brEq, o_brLT, o_mispredict, o_illegal, o_target
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch compare/target unit with a single-entry result register and
// saturating resolved-branch / mispredict statistics counters.
module branch_resolve #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  branch_resolve_if.slave   bus,
  input  logic              i_flush,
  input  logic              i_clr_cnt,
  output logic [CNTW-1:0]   o_br_count,
  output logic [CNTW-1:0]   o_mp_count
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_hs;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic                   w_eq;
  logic                   w_lt;
  logic                   w_taken;
  logic                   w_illegal;
  logic                   w_mispredict;
  logic [XLEN-1:0]        w_target;

  logic                   r_vld_p1;
  logic                   r_taken_p1;
  logic                   r_eq_p1;
  logic                   r_lt_p1;
  logic                   r_mp_p1;
  logic                   r_ill_p1;
  logic [XLEN-1:0]        r_target_p1;
  logic [CNTW-1:0]        r_br_cnt;
  logic [CNTW-1:0]        r_mp_cnt;

  assign w_ready  = !r_vld_p1 || bus.i_ready;
  assign w_accept = bus.i_valid && w_ready && !i_flush;
  assign w_hs     = r_vld_p1 && bus.i_ready;

  assign w_a_s = bus.i_dataA;
  assign w_b_s = bus.i_dataB;
  assign w_eq  = (bus.i_dataA == bus.i_dataB);
  // Strict less-than is already false on equality, so brEq implicitly forces brLT low.
  assign w_lt  = bus.i_funct3[1] ? (bus.i_dataA < bus.i_dataB) : (w_a_s < w_b_s);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (bus.i_funct3)
      3'b000:          w_taken = w_eq;
      3'b001:          w_taken = !w_eq;
      3'b100, 3'b110:  w_taken = w_lt;
      3'b101, 3'b111:  w_taken = !w_lt;
      default:         w_illegal = 1'b1;
    endcase
  end

  assign w_mispredict = !w_illegal && (w_taken != bus.i_pred_taken);
  assign w_target     = w_taken ? (bus.i_pc + bus.i_imm) : (bus.i_pc + PC_STEP);

  // Stage p0 -> p1: result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p1    <= 1'b0;
      r_taken_p1  <= 1'b0;
      r_eq_p1     <= 1'b0;
      r_lt_p1     <= 1'b0;
      r_mp_p1     <= 1'b0;
      r_ill_p1    <= 1'b0;
      r_target_p1 <= '0;
    end else begin
      if (i_flush) begin
        r_vld_p1 <= 1'b0;
      end else if (w_accept) begin
        r_vld_p1 <= 1'b1;
      end else if (w_hs) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_accept) begin
        r_taken_p1  <= w_taken;
        r_eq_p1     <= w_eq;
        r_lt_p1     <= w_lt;
        r_mp_p1     <= w_mispredict;
        r_ill_p1    <= w_illegal;
        r_target_p1 <= w_target;
      end
    end
  end

  // Statistics count only results actually consumed, never flushed or illegal ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_hs && !i_flush && !r_ill_p1) begin
      r_br_cnt <= sat_inc(r_br_cnt);
      if (r_mp_p1) begin
        r_mp_cnt <= sat_inc(r_mp_cnt);
      end
    end
  end

  assign bus.o_ready      = w_ready;
  assign bus.o_valid      = r_vld_p1;
  assign bus.o_taken      = r_taken_p1;
  assign bus.o_brEq       = r_eq_p1;
  assign bus.o_brLT       = r_lt_p1;
  assign bus.o_mispredict = r_mp_p1;
  assign bus.o_illegal    = r_ill_p1;
  assign bus.o_target     = r_target_p1;
  assign o_br_count       = r_br_cnt;
  assign o_mp_count       = r_mp_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized and directed bench for branch_resolve against a cycle-level reference model.
module tb_branch_resolve;
  localparam int XLEN = 32;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct packed {
    logic        taken;
    logic        eq;
    logic        lt;
    logic        mp;
    logic        ill;
    logic [31:0] tgt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic clr = 1'b0;
  logic [CNTW-1:0] br_cnt;
  logic [CNTW-1:0] mp_cnt;

  int checks = 0;
  int errors = 0;

  logic m_vld = 1'b0;
  res_t m_res = '0;
  int   m_br = 0;
  int   m_mp = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

  branch_resolve #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_flush    (flush),
    .i_clr_cnt  (clr),
    .o_br_count (br_cnt),
    .o_mp_count (mp_cnt)
  );

  function automatic res_t ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    res_t   r;
    longint sa, sb, ua, ub, sum;
    logic   t;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    r.eq  = (ua == ub);
    r.lt  = f3[1] ? (ua < ub) : (sa < sb);
    r.ill = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:       t = r.eq;
      3'd1:       t = !r.eq;
      3'd4, 3'd6: t = r.lt;
      3'd5, 3'd7: t = !r.lt;
      default:    t = 1'b0;
    endcase
    r.taken = t;
    r.mp    = r.ill ? 1'b0 : (t != pred);
    sum     = t ? (longint'(pc) + longint'(imm)) : (longint'(pc) + 4);
    r.tgt   = 32'(sum % 64'sh1_0000_0000);
    return r;
  endfunction

  function automatic logic [45:0] dut_vec();
    return {bus.o_valid,
            bus.o_valid ? {bus.o_taken, bus.o_brEq, bus.o_brLT, bus.o_mispredict, bus.o_illegal, bus.o_target}
                        : 37'b0,
            br_cnt, mp_cnt};
  endfunction

  function automatic logic [45:0] exp_vec();
    return {m_vld, m_vld ? m_res : 37'b0, CNTW'(m_br), CNTW'(m_mp)};
  endfunction

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred, input logic rdy);
    bus.i_valid      = v;
    bus.i_funct3     = f3;
    bus.i_dataA      = a;
    bus.i_dataB      = b;
    bus.i_pc         = pc;
    bus.i_imm        = imm;
    bus.i_pred_taken = pred;
    bus.i_ready      = rdy;
  endtask

  // Advance one clock, evolving the model from the inputs present before the edge.
  task automatic step();
    logic hs, rdy_ok, acc, nvld;
    res_t nres;
    int   nbr, nmp;
    hs     = m_vld && bus.i_ready;
    rdy_ok = !m_vld || bus.i_ready;
    acc    = bus.i_valid && rdy_ok && !flush;
    nres   = acc ? ref_res(bus.i_funct3, bus.i_dataA, bus.i_dataB, bus.i_pc, bus.i_imm, bus.i_pred_taken) : m_res;
    nvld   = flush ? 1'b0 : (acc ? 1'b1 : (hs ? 1'b0 : m_vld));
    nbr    = m_br;
    nmp    = m_mp;
    if (clr) begin
      nbr = 0;
      nmp = 0;
    end else if (hs && !flush && !m_res.ill) begin
      nbr = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (m_res.mp) nmp = (m_mp < CMAX) ? m_mp + 1 : CMAX;
    end
    @(posedge clk);
    #1;
    m_vld = nvld;
    m_res = nres;
    m_br  = nbr;
    m_mp  = nmp;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    checks++;
    if ({bus.o_valid, bus.o_ready, bus.o_taken, bus.o_brEq, bus.o_brLT, bus.o_mispredict, bus.o_illegal} !== 7'b0100000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0100000", {bus.o_valid, bus.o_ready, bus.o_taken, bus.o_brEq,
               bus.o_brLT, bus.o_mispredict, bus.o_illegal});
    end
    checks++;
    if ({bus.o_target, br_cnt, mp_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL reset_data got target=%h br=%0d mp=%0d exp 0", bus.o_target, br_cnt, mp_cnt);
    end
    rst_n = 1'b1;
    drive(1'b1, 3'd1, 32'd5, 32'd6, 32'h100, 32'h40, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_target !== 32'h140) begin
      errors++;
      $display("FAIL first_accept got valid=%b target=%h exp valid=1 target=00000140", bus.o_valid, bus.o_target);
    end
  endtask

  task automatic test_signed_unsigned();
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h20, 1'b0, 1'b1);
    step();
    checks++;
    if ({bus.o_taken, bus.o_brLT} !== 2'b11) begin
      errors++;
      $display("FAIL blt_signed got taken/lt=%b exp 11", {bus.o_taken, bus.o_brLT});
    end
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h20, 1'b0, 1'b1);
    step();
    checks++;
    if ({bus.o_taken, bus.o_brLT} !== 2'b00) begin
      errors++;
      $display("FAIL bltu_unsigned got taken/lt=%b exp 00", {bus.o_taken, bus.o_brLT});
    end
  endtask

  task automatic test_target_wrap();
    drive(1'b1, 3'b000, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.o_target !== 32'h0000_0004 || bus.o_taken !== 1'b1) begin
      errors++;
      $display("FAIL wrap_beq got target=%h taken=%b exp 00000004 1", bus.o_target, bus.o_taken);
    end
    drive(1'b1, 3'b001, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.o_target !== 32'h0000_0000 || bus.o_mispredict !== 1'b1) begin
      errors++;
      $display("FAIL wrap_bne got target=%h mp=%b exp 00000000 1", bus.o_target, bus.o_mispredict);
    end
  endtask

  task automatic test_stall();
    logic [45:0] held;
    drive(1'b1, 3'b101, 32'd3, 32'd9, 32'h2000, 32'h80, 1'b1, 1'b1);
    step();
    held = dut_vec();
    drive(1'b1, 3'b000, 32'd7, 32'd7, 32'h3000, 32'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle %0d got %b exp 0", i, bus.o_ready);
      end
      step();
      checks++;
      if (dut_vec() !== held || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    bus.i_ready = 1'b1;
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_target !== 32'h3010 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stall_release got %h exp %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid got %b exp 0", bus.o_valid);
    end
  endtask

  task automatic test_flush();
    logic [CNTW-1:0] sb, sm;
    drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0, 1'b1);
    step();
    sb = br_cnt;
    sm = mp_cnt;
    drive(1'b1, 3'b000, 32'd4, 32'd4, 32'h500, 32'h8, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || br_cnt !== sb || mp_cnt !== sm) begin
      errors++;
      $display("FAIL flush got valid=%b br=%0d mp=%0d exp valid=0 br=%0d mp=%0d", bus.o_valid, br_cnt, mp_cnt, sb, sm);
    end
  endtask

  task automatic test_counters();
    clr = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'b101, 32'(i), 32'(i), 32'h8000, 32'h40, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    checks++;
    if (br_cnt !== 4'd15 || mp_cnt !== 4'd15) begin
      errors++;
      $display("FAIL counter_sat got br=%0d mp=%0d exp 15 15", br_cnt, mp_cnt);
    end
    drive(1'b1, 3'b101, 32'd1, 32'd1, 32'h8000, 32'h40, 1'b0, 1'b1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (br_cnt !== 4'd0 || mp_cnt !== 4'd0) begin
      errors++;
      $display("FAIL counter_clr got br=%0d mp=%0d exp 0 0", br_cnt, mp_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 24) == 0);
      #1;
      checks++;
      if (bus.o_ready !== (!m_vld || bus.i_ready)) begin
        errors++;
        $display("FAIL rand_ready iter %0d got %b exp %b", i, bus.o_ready, !m_vld || bus.i_ready);
      end
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_result iter %0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    flush = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'b100, 32'd1, 32'd2, 32'h600, 32'h20, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup got valid=%b exp 1", bus.o_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_target !== 32'd0) begin
      errors++;
      $display("FAIL arst_immediate got valid=%b ready=%b target=%h exp 0 1 00000000",
               bus.o_valid, bus.o_ready, bus.o_target);
    end
    m_vld = 1'b0;
    m_res = '0;
    m_br  = 0;
    m_mp  = 0;
    #2;
    rst_n = 1'b1;
    drive(1'b1, 3'b111, 32'd9, 32'd2, 32'h700, 32'h10, 1'b1, 1'b1);
    step();
    checks++;
    if (dut_vec() !== exp_vec() || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_recover got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_target_wrap();
    test_stall();
    test_flush();
    test_counters();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
